// File: rtl/uart_cmd_bridge.sv
// rtl/uart_cmd_bridge.sv - UART byte command parser driving single-byte bus reads/writes
// Parses 0x52/0x57 packets, performs the bus access, returns one response byte.
module uart_cmd_bridge #(
    parameter int CLKS_TIMEOUT = 65535
) (
    input  logic        i_Clock,
    input  logic        i_Rst_n,
    input  logic        i_RX_DV,
    input  logic [7:0]  i_RX_Byte,
    output logic        o_TX_DV,
    output logic [7:0]  o_TX_Byte,
    input  logic        i_TX_Active,
    output logic [15:0] o_Bus_Addr,
    output logic [7:0]  o_Bus_WData,
    output logic        o_Bus_WE,
    output logic        o_Bus_RE,
    input  logic [7:0]  i_Bus_RData,
    input  logic        i_Bus_Ack,
    output logic        o_Busy,
    output logic        o_Overrun
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR_HI,
        S_ADDR_LO,
        S_WDATA,
        S_BUS,
        S_TX_SEND,
        S_TX_WAIT_HI,
        S_TX_WAIT_LO,
        S_TX_GAP
    } state_t;

    localparam logic [7:0]  OP_READ     = 8'h52;
    localparam logic [7:0]  OP_WRITE    = 8'h57;
    localparam logic [7:0]  RSP_OK      = 8'h4B;
    localparam logic [7:0]  RSP_BAD     = 8'h3F;
    localparam logic [15:0] TIMEOUT_VAL = 16'(CLKS_TIMEOUT);

    state_t      r_state;
    state_t      w_next_state;
    logic        r_is_write;
    logic [15:0] r_addr;
    logic [7:0]  r_wdata;
    logic [7:0]  r_tx_byte;
    logic [15:0] r_timeout_cnt;
    logic        r_overrun;
    logic        w_collecting;
    logic        w_timeout;
    logic        w_valid_op;
    logic        w_drop;

    always_comb begin
        w_collecting = (r_state == S_ADDR_HI) || (r_state == S_ADDR_LO) || (r_state == S_WDATA);
        w_timeout    = w_collecting && !i_RX_DV && (r_timeout_cnt == TIMEOUT_VAL);
        w_valid_op   = (i_RX_Byte == OP_READ) || (i_RX_Byte == OP_WRITE);
        // Bytes that land while the bridge is busy with an access or a response are discarded
        w_drop       = i_RX_DV && !w_collecting && (r_state != S_IDLE);
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:       if (i_RX_DV) w_next_state = w_valid_op ? S_ADDR_HI : S_TX_SEND;
            S_ADDR_HI:    if (i_RX_DV) w_next_state = S_ADDR_LO;
                          else if (w_timeout) w_next_state = S_IDLE;
            S_ADDR_LO:    if (i_RX_DV) w_next_state = r_is_write ? S_WDATA : S_BUS;
                          else if (w_timeout) w_next_state = S_IDLE;
            S_WDATA:      if (i_RX_DV) w_next_state = S_BUS;
                          else if (w_timeout) w_next_state = S_IDLE;
            S_BUS:        if (i_Bus_Ack) w_next_state = S_TX_SEND;
            S_TX_SEND:    w_next_state = S_TX_WAIT_HI;
            S_TX_WAIT_HI: if (i_TX_Active) w_next_state = S_TX_WAIT_LO;
            S_TX_WAIT_LO: if (!i_TX_Active) w_next_state = S_TX_GAP;
            S_TX_GAP:     w_next_state = S_IDLE;
            default:      w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_state       <= S_IDLE;
            r_is_write    <= 1'b0;
            r_addr        <= 16'h0000;
            r_wdata       <= 8'h00;
            r_tx_byte     <= 8'h00;
            r_timeout_cnt <= 16'h0000;
            r_overrun     <= 1'b0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                S_IDLE: if (i_RX_DV) begin
                    r_is_write <= (i_RX_Byte == OP_WRITE);
                    if (!w_valid_op) r_tx_byte <= RSP_BAD;
                end
                S_ADDR_HI: if (i_RX_DV) r_addr[15:8] <= i_RX_Byte;
                S_ADDR_LO: if (i_RX_DV) r_addr[7:0] <= i_RX_Byte;
                S_WDATA:   if (i_RX_DV) r_wdata <= i_RX_Byte;
                S_BUS:     if (i_Bus_Ack) r_tx_byte <= r_is_write ? RSP_OK : i_Bus_RData;
                default:   ;
            endcase
            if (w_collecting && !i_RX_DV && !w_timeout)
                r_timeout_cnt <= r_timeout_cnt + 16'd1;
            else
                r_timeout_cnt <= 16'h0000;
            if (w_drop) r_overrun <= 1'b1;
        end
    end

    // Requests and the DV pulse decode straight from state so reset drops them immediately
    assign o_Bus_WE    = (r_state == S_BUS) && r_is_write;
    assign o_Bus_RE    = (r_state == S_BUS) && !r_is_write;
    assign o_TX_DV     = (r_state == S_TX_SEND);
    assign o_Busy      = (r_state != S_IDLE);
    assign o_TX_Byte   = r_tx_byte;
    assign o_Bus_Addr  = r_addr;
    assign o_Bus_WData = r_wdata;
    assign o_Overrun   = r_overrun;

endmodule

// File: tb/tb_uart_cmd_bridge.sv
// tb/tb_uart_cmd_bridge.sv - directed self-checking bench for uart_cmd_bridge
module tb_uart_cmd_bridge;

    logic        i_Clock = 1'b0;
    logic        i_Rst_n = 1'b0;
    logic        i_RX_DV = 1'b0;
    logic [7:0]  i_RX_Byte = 8'h00;
    logic        o_TX_DV;
    logic [7:0]  o_TX_Byte;
    logic        i_TX_Active = 1'b0;
    logic [15:0] o_Bus_Addr;
    logic [7:0]  o_Bus_WData;
    logic        o_Bus_WE;
    logic        o_Bus_RE;
    logic [7:0]  i_Bus_RData = 8'h00;
    logic        i_Bus_Ack = 1'b0;
    logic        o_Busy;
    logic        o_Overrun;

    int n_checks = 0;
    int n_fail   = 0;

    int          cyc = 0;
    int          ack_delay = 0;
    logic [7:0]  rdata_val = 8'h00;
    int          bus_wait = 0;
    int          ack_cyc = 0;
    int          we_cycles = 0;
    int          re_cycles = 0;
    logic [15:0] we_addr = 16'h0;
    logic [7:0]  we_data = 8'h0;
    logic [15:0] re_addr = 16'h0;
    int          dv_count = 0;
    int          dv_cyc = 0;
    logic [7:0]  dv_byte = 8'h0;
    logic        dv_prev = 1'b0;
    int          tx_hold = 0;
    int          base_dv, base_we, base_re;

    uart_cmd_bridge #(.CLKS_TIMEOUT(16)) dut (
        .i_Clock     (i_Clock),
        .i_Rst_n     (i_Rst_n),
        .i_RX_DV     (i_RX_DV),
        .i_RX_Byte   (i_RX_Byte),
        .o_TX_DV     (o_TX_DV),
        .o_TX_Byte   (o_TX_Byte),
        .i_TX_Active (i_TX_Active),
        .o_Bus_Addr  (o_Bus_Addr),
        .o_Bus_WData (o_Bus_WData),
        .o_Bus_WE    (o_Bus_WE),
        .o_Bus_RE    (o_Bus_RE),
        .i_Bus_RData (i_Bus_RData),
        .i_Bus_Ack   (i_Bus_Ack),
        .o_Busy      (o_Busy),
        .o_Overrun   (o_Overrun)
    );

    always #5 i_Clock = ~i_Clock;

    // Bus slave, transmitter model and monitor, all on the falling edge
    always @(negedge i_Clock) begin
        cyc = cyc + 1;
        if (o_Bus_WE) begin we_cycles++; we_addr = o_Bus_Addr; we_data = o_Bus_WData; end
        if (o_Bus_RE) begin re_cycles++; re_addr = o_Bus_Addr; end
        if (o_Bus_WE || o_Bus_RE) begin
            if (bus_wait == ack_delay) begin
                i_Bus_Ack = 1'b1; i_Bus_RData = rdata_val; ack_cyc = cyc;
            end else begin
                i_Bus_Ack = 1'b0;
            end
            bus_wait++;
        end else begin
            bus_wait = 0; i_Bus_Ack = 1'b0;
        end
        if (dv_prev) begin
            i_TX_Active = 1'b1; tx_hold = 4;
        end else if (tx_hold > 0) begin
            tx_hold--;
            if (tx_hold == 0) i_TX_Active = 1'b0;
        end
        if (o_TX_DV) begin dv_count++; dv_cyc = cyc; dv_byte = o_TX_Byte; end
        dv_prev = o_TX_DV;
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge i_Clock);
        i_RX_DV = 1'b1; i_RX_Byte = b;
        @(negedge i_Clock);
        i_RX_DV = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (o_Busy && n < 300) begin @(negedge i_Clock); n++; end
        check_eq(tag, o_Busy, 1'b0);
        repeat (2) @(negedge i_Clock);
    endtask

    task automatic snap();
        base_dv = dv_count; base_we = we_cycles; base_re = re_cycles;
    endtask

    initial begin
        repeat (3) @(negedge i_Clock);
        check_eq("rst_tx_dv", o_TX_DV, 0);
        check_eq("rst_tx_byte", o_TX_Byte, 0);
        check_eq("rst_addr", o_Bus_Addr, 0);
        check_eq("rst_wdata", o_Bus_WData, 0);
        check_eq("rst_we_re", {o_Bus_WE, o_Bus_RE}, 0);
        check_eq("rst_busy", o_Busy, 0);
        check_eq("rst_overrun", o_Overrun, 0);
        i_Rst_n = 1'b1;
        repeat (2) @(negedge i_Clock);

        // Write with ack on the fourth request cycle
        snap(); ack_delay = 3;
        send_byte(8'h57); send_byte(8'h12); send_byte(8'h34); send_byte(8'hA5);
        wait_idle("wr_idle");
        check_eq("wr_we_cycles", we_cycles - base_we, 4);
        check_eq("wr_addr", we_addr, 16'h1234);
        check_eq("wr_data", we_data, 8'hA5);
        check_eq("wr_no_re", re_cycles - base_re, 0);
        check_eq("wr_dv_count", dv_count - base_dv, 1);
        check_eq("wr_rsp", dv_byte, 8'h4B);
        check_eq("wr_addr_hold", o_Bus_Addr, 16'h1234);

        // Read with zero-wait ack
        snap(); ack_delay = 0; rdata_val = 8'h3C;
        send_byte(8'h52); send_byte(8'h80); send_byte(8'h00);
        wait_idle("rd_idle");
        check_eq("rd_re_cycles", re_cycles - base_re, 1);
        check_eq("rd_addr", re_addr, 16'h8000);
        check_eq("rd_dv_count", dv_count - base_dv, 1);
        check_eq("rd_rsp", dv_byte, 8'h3C);
        check_eq("rd_ack_to_dv", dv_cyc - ack_cyc, 1);

        // Unknown opcode
        snap();
        send_byte(8'h00);
        wait_idle("bad_idle");
        check_eq("bad_no_req", (we_cycles - base_we) + (re_cycles - base_re), 0);
        check_eq("bad_dv_count", dv_count - base_dv, 1);
        check_eq("bad_rsp", dv_byte, 8'h3F);
        snap(); ack_delay = 1; rdata_val = 8'h77;
        send_byte(8'h52); send_byte(8'h00); send_byte(8'h10);
        wait_idle("bad_next_idle");
        check_eq("bad_next_addr", re_addr, 16'h0010);
        check_eq("bad_next_rsp", dv_byte, 8'h77);

        // Inter-byte timeout
        snap();
        send_byte(8'h57); send_byte(8'h12);
        repeat (20) @(negedge i_Clock);
        check_eq("to_idle", o_Busy, 0);
        check_eq("to_no_we", we_cycles - base_we, 0);
        check_eq("to_no_dv", dv_count - base_dv, 0);
        ack_delay = 2;
        send_byte(8'h57); send_byte(8'hBE); send_byte(8'hEF); send_byte(8'h5A);
        wait_idle("to_next_idle");
        check_eq("to_next_addr", we_addr, 16'hBEEF);
        check_eq("to_next_data", we_data, 8'h5A);
        check_eq("to_next_rsp", dv_byte, 8'h4B);

        // Overrun during TX_WAIT_LO
        snap(); ack_delay = 2; rdata_val = 8'h99;
        check_eq("ovr_pre", o_Overrun, 0);
        send_byte(8'h52); send_byte(8'h00); send_byte(8'h42);
        begin
            int n = 0;
            while (!i_TX_Active && n < 100) begin @(posedge i_Clock); n++; end
            check_eq("ovr_active_seen", i_TX_Active, 1);
        end
        @(negedge i_Clock);
        i_RX_DV = 1'b1; i_RX_Byte = 8'h57;
        @(negedge i_Clock);
        i_RX_DV = 1'b0;
        check_eq("ovr_set", o_Overrun, 1);
        wait_idle("ovr_idle");
        check_eq("ovr_dv_count", dv_count - base_dv, 1);
        check_eq("ovr_rsp", dv_byte, 8'h99);
        check_eq("ovr_sticky", o_Overrun, 1);

        // Reset while a read is pending
        snap(); ack_delay = 1000;
        send_byte(8'h52); send_byte(8'h12); send_byte(8'h00);
        begin
            int n = 0;
            while (!o_Bus_RE && n < 20) begin @(negedge i_Clock); n++; end
            check_eq("rstmid_re_seen", o_Bus_RE, 1);
        end
        #2 i_Rst_n = 1'b0;
        #1;
        check_eq("rstmid_re", o_Bus_RE, 0);
        check_eq("rstmid_dv", o_TX_DV, 0);
        check_eq("rstmid_busy", o_Busy, 0);
        check_eq("rstmid_overrun", o_Overrun, 0);
        repeat (2) @(negedge i_Clock);
        i_Rst_n = 1'b1;
        snap(); ack_delay = 0; rdata_val = 8'h5A;
        send_byte(8'h52); send_byte(8'h00); send_byte(8'hFF);
        wait_idle("rstmid_next_idle");
        check_eq("rstmid_next_re", re_cycles - base_re, 1);
        check_eq("rstmid_next_addr", re_addr, 16'h00FF);
        check_eq("rstmid_next_rsp", dv_byte, 8'h5A);
        check_eq("rstmid_next_dv", dv_count - base_dv, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_cmd_bridge.md
# uart_cmd_bridge

Byte-level command responder between a UART byte receiver/transmitter pair and the system control bus. It parses host command packets from received bytes, performs single-byte reads and writes on a 16-bit-address bus with an ack handshake, and returns a one-byte response through the transmitter's DV/Active handshake. It sits in SYS_CTRL and gives a host PC debug and load access to emulator memory.

## Interface
- CLKS_TIMEOUT, default 65535: inter-byte timeout in clocks while mid-packet; 16-bit counter.
- i_Clock  in  1  system clock; all logic is on the rising edge.
- i_Rst_n  in  1  asynchronous active-low reset.
- i_RX_DV  in  1  one-cycle pulse: i_RX_Byte is valid.
- i_RX_Byte  in  8  received byte.
- o_TX_DV  out  1  one-cycle pulse that requests transmission of o_TX_Byte.
- o_TX_Byte  out  8  response byte; stable from the o_TX_DV pulse until the transmit completes.
- i_TX_Active  in  1  transmitter busy; rises one clock after an accepted o_TX_DV.
- o_Bus_Addr  out  16  bus address.
- o_Bus_WData  out  8  bus write data.
- o_Bus_WE  out  1  write request; held until ack.
- o_Bus_RE  out  1  read request; held until ack.
- i_Bus_RData  in  8  read data; sampled on the ack cycle.
- i_Bus_Ack  in  1  one-cycle completion pulse.
- o_Busy  out  1  high in every state except IDLE.
- o_Overrun  out  1  sticky until reset; set when a byte arrives while in BUS or any TX state.

## Operation
- Packet formats:
  - Read: 0x52, addr_hi, addr_lo. Response: the read data byte.
  - Write: 0x57, addr_hi, addr_lo, data. Response: 0x4B.
  - Any other first byte: response 0x3F, then the bridge returns to IDLE.
- States:
  - IDLE: on RX_DV, latch the opcode. A valid opcode goes to ADDR_HI; an invalid one goes to TX_SEND with byte 0x3F.
  - ADDR_HI: on RX_DV, load o_Bus_Addr[15:8], then go to ADDR_LO.
  - ADDR_LO: on RX_DV, load o_Bus_Addr[7:0]. A read goes to BUS; a write goes to WDATA.
  - WDATA: on RX_DV, load o_Bus_WData, then go to BUS.
  - BUS: assert RE or WE until i_Bus_Ack. On ack, drop the request in the same edge, latch the response byte (RData or 0x4B), and go to TX_SEND.
  - TX_SEND: pulse o_TX_DV for exactly one cycle, then go to TX_WAIT_HI.
  - TX_WAIT_HI: wait for i_TX_Active = 1, then go to TX_WAIT_LO.
  - TX_WAIT_LO: wait for i_TX_Active = 0, then go to TX_GAP.
  - TX_GAP: one cycle, covering the transmitter's cleanup cycle, then go to IDLE.
- Timeout: in ADDR_HI, ADDR_LO and WDATA, the counter clears on every RX_DV and increments otherwise. When it reaches CLKS_TIMEOUT, go to IDLE silently: no bus access and no response.
- Bytes arriving in BUS or any TX state are dropped and set o_Overrun. The packet in progress is unaffected.
- RX_DV in IDLE on the same cycle that TX_GAP exits cannot happen, because IDLE is entered only after TX_GAP.
- i_Bus_Ack outside BUS is ignored.
- Reset values: all outputs 0, state IDLE, counters 0. o_TX_Byte resets to 0x00.
- Reset mid-operation aborts immediately: requests drop asynchronously and no response is sent.

## Timing
- Byte accept: the state advances on the edge where i_RX_DV = 1. Address and data registers update on that same edge.
- Bus request rises on the edge that accepts the last packet byte, so it is visible the next cycle.
- Zero-wait ack (ack on the first request cycle) is legal. In that case o_TX_DV pulses on the cycle after the ack cycle.
- Ack-to-DV latency is 1 cycle. The next packet is accepted no earlier than 1 cycle after i_TX_Active falls (TX_GAP).
- o_Bus_Addr and o_Bus_WData hold their values after the access until overwritten.

## Test plan
- Write: bytes 0x57 0x12 0x34 0xA5, ack after 3 cycles -> o_Bus_WE high with Addr=0x1234 and WData=0xA5 until ack; exactly one DV with TX_Byte=0x4B; o_Busy low after the gap cycle.
- Read: bytes 0x52 0x80 0x00, zero-wait ack with RData=0x3C -> one RE cycle at 0x8000; DV with 0x3C the following cycle; model transmitter's Active waveform honored.
- Bad opcode 0x00 -> no bus request; response 0x3F; bridge idle and accepts the next read normally.
- Timeout with CLKS_TIMEOUT=16: send 0x57 0x12 then silence for 20 cycles -> returns to IDLE, no WE, no DV; a subsequent full write completes.
- Overrun: inject a byte while in TX_WAIT_LO -> o_Overrun=1 and stays 1; the response still completes.
- Reset asserted while RE is pending -> RE, DV and Busy go 0 immediately; after release a read works.
